// File: rtl/mac_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : mac_sequencer_pkg
// Brief  : Q-format constants and FSM state encoding for mac_sequencer.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package mac_sequencer_pkg;

  localparam int Q_INT  = 8;
  localparam int Q_FRAC = 8;
  localparam int Q_SIZE = Q_INT + Q_FRAC;

  localparam logic [Q_SIZE-1:0] ONE = Q_SIZE'(1) << Q_FRAC;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    LAST    = 3'd2,
    BIAS    = 3'd3,
    CAPTURE = 3'd4,
    RESULT  = 3'd5
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/mac_sequencer_seq_addr_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : mac_sequencer_seq_addr_gen
// Brief  : Address walker, term counter and one-cycle read-return pipeline.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module mac_sequencer_seq_addr_gen #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] x_base,
  input  logic [ADDR_W-1:0] w_base,
  output logic [ADDR_W-1:0] x_addr,
  output logic [ADDR_W-1:0] w_addr,
  output logic              last_term,
  output logic              rd_en_q,
  output logic              first_q
);

  logic [ADDR_W-1:0] x_addr_q, x_addr_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              rd_en_d, first_d;

  always_comb begin
    x_addr_d = x_addr_q;
    w_addr_d = w_addr_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    if (load) begin
      x_addr_d = x_base;
      w_addr_d = w_base;
      cnt_d    = '0;
      len_d    = len;
    end else if (step) begin
      // Natural overflow gives the modulo-2**ADDR_W wrap.
      x_addr_d = x_addr_q + ADDR_W'(1);
      w_addr_d = w_addr_q + ADDR_W'(1);
      cnt_d    = cnt_q + LEN_W'(1);
    end
    rd_en_d = step;
    first_d = step && (cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_addr_q <= '0;
      w_addr_q <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      rd_en_q  <= 1'b0;
      first_q  <= 1'b0;
    end else begin
      x_addr_q <= x_addr_d;
      w_addr_q <= w_addr_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      rd_en_q  <= rd_en_d;
      first_q  <= first_d;
    end
  end

  assign x_addr    = x_addr_q;
  assign w_addr    = w_addr_q;
  assign last_term = (cnt_q == len_q - LEN_W'(1));

endmodule
`default_nettype wire

// File: rtl/mac_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : mac_sequencer
// Brief  : Drives one MacUnit lane through a dot product and hands off result.
//          Optional bias term enabled by defining MAC_SEQ_BIAS_EN.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module mac_sequencer
  import mac_sequencer_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] x_base,
  input  logic [ADDR_W-1:0] w_base,
`ifdef MAC_SEQ_BIAS_EN
  input  logic [Q_SIZE-1:0] bias,
`endif
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] x_addr,
  output logic [ADDR_W-1:0] w_addr,
  input  logic [Q_SIZE-1:0] x_rdata,
  input  logic [Q_SIZE-1:0] w_rdata,
  output logic [Q_SIZE-1:0] mac_x,
  output logic [Q_SIZE-1:0] mac_w,
  output logic              mac_acc_loopback,
  output logic              mac_acc_update,
  input  logic [Q_SIZE-1:0] acc,
  output logic [Q_SIZE-1:0] result,
  output logic              result_valid,
  input  logic              result_ready
);

  seq_state_t        state_q, state_d;
  logic [Q_SIZE-1:0] result_q, result_d;
  logic              result_valid_q, result_valid_d;
  logic              zero_len_q, zero_len_d;
  logic              accept, last_term, rd_en_q, first_q;
`ifdef MAC_SEQ_BIAS_EN
  logic [Q_SIZE-1:0] bias_q, bias_d;
`endif

  assign accept = (state_q == IDLE) && start;

  mac_sequencer_seq_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .step      (rd_en),
    .len       (len),
    .x_base    (x_base),
    .w_base    (w_base),
    .x_addr    (x_addr),
    .w_addr    (w_addr),
    .last_term (last_term),
    .rd_en_q   (rd_en_q),
    .first_q   (first_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      zero_len_q     <= 1'b0;
`ifdef MAC_SEQ_BIAS_EN
      bias_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      zero_len_q     <= zero_len_d;
`ifdef MAC_SEQ_BIAS_EN
      bias_q         <= bias_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d = RUN;
          end else begin
`ifdef MAC_SEQ_BIAS_EN
            state_d = BIAS;
`else
            // Empty product still takes one cycle so valid lands at cycle 2.
            state_d = CAPTURE;
`endif
          end
        end
      end
      RUN:     if (last_term) state_d = LAST;
`ifdef MAC_SEQ_BIAS_EN
      LAST:    state_d = BIAS;
`else
      LAST:    state_d = CAPTURE;
`endif
      BIAS:    state_d = CAPTURE;
      CAPTURE: state_d = RESULT;
      RESULT:  if (result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    zero_len_d     = zero_len_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
`ifdef MAC_SEQ_BIAS_EN
    bias_d         = bias_q;
    if (accept) bias_d = bias;
`endif
    if (accept) zero_len_d = (len == '0);
    if (state_q == CAPTURE) begin
`ifdef MAC_SEQ_BIAS_EN
      result_d = acc;
`else
      // acc is never written for an empty product, so it may hold stale data.
      result_d = zero_len_q ? '0 : acc;
`endif
      result_valid_d = 1'b1;
    end else if ((state_q == RESULT) && result_ready) begin
      result_valid_d = 1'b0;
    end
  end

  always_comb begin
    busy             = (state_q != IDLE);
    rd_en            = (state_q == RUN);
    mac_x            = x_rdata;
    mac_w            = w_rdata;
    mac_acc_update   = rd_en_q;
    mac_acc_loopback = rd_en_q && !first_q;
`ifdef MAC_SEQ_BIAS_EN
    if (state_q == BIAS) begin
      mac_x            = ONE;
      mac_w            = bias_q;
      mac_acc_update   = 1'b1;
      mac_acc_loopback = !zero_len_q;
    end
`endif
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_mac_sequencer
// Brief  : Directed bench with a Q8.8 saturating MacUnit stand-in and memories.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_mac_sequencer;
  import mac_sequencer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, start = 1'b0, result_ready = 1'b0;
  logic [8:0]  len = '0;
  logic [9:0]  x_base = '0, w_base = '0;
  logic        busy, rd_en, mac_acc_loopback, mac_acc_update, result_valid;
  logic [9:0]  x_addr, w_addr;
  logic [15:0] x_rdata = '0, w_rdata = '0, mac_x, mac_w, result;
  logic [15:0] acc_m = 16'h1234;
`ifdef MAC_SEQ_BIAS_EN
  logic [15:0] bias = '0;
`endif

  logic [15:0] x_mem [0:1023];
  logic [15:0] w_mem [0:1023];

  int total = 0, bad = 0;
  logic [31:0] rd_mask, upd_mask;
  int          vcycle;
  logic [9:0]  xa [0:31];

  mac_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .x_base(x_base), .w_base(w_base),
`ifdef MAC_SEQ_BIAS_EN
    .bias(bias),
`endif
    .busy(busy), .rd_en(rd_en), .x_addr(x_addr), .w_addr(w_addr),
    .x_rdata(x_rdata), .w_rdata(w_rdata), .mac_x(mac_x), .mac_w(mac_w),
    .mac_acc_loopback(mac_acc_loopback), .mac_acc_update(mac_acc_update),
    .acc(acc_m), .result(result), .result_valid(result_valid), .result_ready(result_ready)
  );

  function automatic logic [15:0] mac_f(input logic [15:0] a, input logic [15:0] x,
                                        input logic [15:0] w, input logic lb);
    logic signed [31:0] p, s;
    p = $signed(x) * $signed(w);
    p = p >>> 8;
    s = lb ? p + {{16{a[15]}}, a} : p;
    if (s > 32'sd32767) s = 32'sd32767;
    if (s < -32'sd32768) s = -32'sd32768;
    return s[15:0];
  endfunction

  always @(posedge clk) begin
    if (rd_en) begin
      x_rdata <= x_mem[x_addr];
      w_rdata <= w_mem[w_addr];
    end
    if (mac_acc_update) acc_m <= mac_f(acc_m, mac_x, mac_w, mac_acc_loopback);
  end

  // Start at edge 0; sample cycle c at #1 after edge c-1 until result_valid.
  task automatic run_op(input logic [8:0] n, input logic [9:0] xb, input logic [9:0] wb,
                        input int pulse_at);
    @(negedge clk);
    start = 1'b1; len = n; x_base = xb; w_base = wb;
    @(posedge clk); #1;
    start = 1'b0;
    rd_mask = '0; upd_mask = '0; vcycle = 0;
    for (int c = 1; c <= 30; c++) begin
      if (c == pulse_at) begin start = 1'b1; len = 9'd1; x_base = 10'h000; end
      else start = 1'b0;
      rd_mask[c]  = rd_en;
      upd_mask[c] = mac_acc_update;
      xa[c]       = x_addr;
      if (result_valid) begin vcycle = c; break; end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if ({busy, rd_en, mac_acc_update, mac_acc_loopback, result_valid} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=00000", {busy, rd_en, mac_acc_update, mac_acc_loopback, result_valid}); end
    total++; if ({x_addr, w_addr, result} !== 36'h0) begin
      bad++; $display("FAIL reset_data got=%h want=0", {x_addr, w_addr, result}); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    run_op(9'd3, 10'h010, 10'h200, 0);
    total++; if (result !== 16'hFF00) begin bad++; $display("FAIL basic_result got=%h want=ff00", result); end
    total++; if (vcycle !== 6) begin bad++; $display("FAIL basic_valid_cycle got=%0d want=6", vcycle); end
    total++; if (rd_mask !== 32'h0000_000E) begin bad++; $display("FAIL basic_rd_en got=%h want=0000000e", rd_mask); end
    total++; if (upd_mask !== 32'h0000_001C) begin bad++; $display("FAIL basic_update got=%h want=0000001c", upd_mask); end
    total++; if (xa[1] !== 10'h010) begin bad++; $display("FAIL basic_first_addr got=%h want=010", xa[1]); end
    result_ready = 1'b1; @(posedge clk); #1; result_ready = 1'b0;
    total++; if ({result_valid, busy} !== 2'b00) begin bad++; $display("FAIL basic_release got=%b want=00", {result_valid, busy}); end
  endtask

  task automatic test_zero_len;
    run_op(9'd0, 10'h010, 10'h200, 0);
    total++; if (vcycle !== 2) begin bad++; $display("FAIL zero_valid_cycle got=%0d want=2", vcycle); end
    total++; if (result !== 16'h0000) begin bad++; $display("FAIL zero_result got=%h want=0000", result); end
    total++; if ({rd_mask, upd_mask} !== 64'h0) begin bad++; $display("FAIL zero_no_activity got=%h want=0", {rd_mask, upd_mask}); end
    result_ready = 1'b1; @(posedge clk); #1; result_ready = 1'b0;
  endtask

  task automatic test_saturate_hold;
    run_op(9'd4, 10'h020, 10'h220, 0);
    total++; if (vcycle !== 7) begin bad++; $display("FAIL sat_valid_cycle got=%0d want=7", vcycle); end
    repeat (5) @(posedge clk);
    #1;
    total++; if ({result_valid, result} !== {1'b1, 16'h7FFF}) begin
      bad++; $display("FAIL sat_hold got=%b/%h want=1/7fff", result_valid, result); end
    result_ready = 1'b1; @(posedge clk); #1; result_ready = 1'b0;
    total++; if ({result_valid, busy} !== 2'b00) begin bad++; $display("FAIL sat_release got=%b want=00", {result_valid, busy}); end
  endtask

  task automatic test_reset_mid_run;
    @(negedge clk);
    start = 1'b1; len = 9'd5; x_base = 10'h040; w_base = 10'h240;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    total++; if ({rd_en, x_addr} !== {1'b1, 10'h041}) begin bad++; $display("FAIL midrst_term2 got=%b/%h want=1/041", rd_en, x_addr); end
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    total++; if ({busy, rd_en, mac_acc_update, mac_acc_loopback, result_valid, x_addr, w_addr, result} !== 41'h0) begin
      bad++; $display("FAIL midrst_clear got=%b%b%b%b%b %h %h %h want=all zero", busy, rd_en, mac_acc_update,
                      mac_acc_loopback, result_valid, x_addr, w_addr, result); end
    run_op(9'd2, 10'h040, 10'h240, 0);
    total++; if ({vcycle[3:0], result} !== {4'd5, 16'h0100}) begin
      bad++; $display("FAIL midrst_rerun got=%0d/%h want=5/0100", vcycle, result); end
    result_ready = 1'b1; @(posedge clk); #1; result_ready = 1'b0;
  endtask

  task automatic test_wrap_ignore_start;
    run_op(9'd4, 10'h3FE, 10'h100, 2);
    total++; if ({xa[1], xa[2], xa[3], xa[4]} !== {10'h3FE, 10'h3FF, 10'h000, 10'h001}) begin
      bad++; $display("FAIL wrap_addr got=%h %h %h %h want=3fe 3ff 000 001", xa[1], xa[2], xa[3], xa[4]); end
    total++; if (rd_mask !== 32'h0000_001E) begin bad++; $display("FAIL wrap_rd_en got=%h want=0000001e", rd_mask); end
    total++; if ({vcycle[3:0], result} !== {4'd7, 16'h0A00}) begin
      bad++; $display("FAIL wrap_result got=%0d/%h want=7/0a00", vcycle, result); end
    result_ready = 1'b1; @(posedge clk); #1; result_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    result_ready = 1'b1;
    run_op(9'd0, 10'h010, 10'h200, 0);
    @(posedge clk); #1;
    total++; if ({result_valid, busy} !== 2'b00) begin bad++; $display("FAIL b2b_pulse got=%b want=00", {result_valid, busy}); end
    run_op(9'd1, 10'h010, 10'h200, 0);
    total++; if ({vcycle[3:0], result} !== {4'd4, 16'h0080}) begin
      bad++; $display("FAIL b2b_second got=%0d/%h want=4/0080", vcycle, result); end
    @(posedge clk); #1;
    result_ready = 1'b0;
  endtask

`ifdef MAC_SEQ_BIAS_EN
  task automatic test_bias;
    bias = 16'hFF80;
    run_op(9'd2, 10'h060, 10'h260, 0);
    total++; if ({vcycle[3:0], result} !== {4'd6, 16'h0180}) begin
      bad++; $display("FAIL bias_result got=%0d/%h want=6/0180", vcycle, result); end
    result_ready = 1'b1; @(posedge clk); #1; result_ready = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) begin x_mem[i] = '0; w_mem[i] = '0; end
    x_mem[10'h010] = 16'h0100; x_mem[10'h011] = 16'h0200; x_mem[10'h012] = 16'hFF80;
    w_mem[10'h200] = 16'h0080; w_mem[10'h201] = 16'h0040; w_mem[10'h202] = 16'h0400;
    for (int i = 0; i < 4; i++) begin x_mem[10'h020 + i] = 16'h6400; w_mem[10'h220 + i] = 16'h0100; end
    x_mem[10'h040] = 16'h0300; x_mem[10'h041] = 16'h0100;
    w_mem[10'h240] = 16'h0100; w_mem[10'h241] = 16'hFE00;
    x_mem[10'h3FE] = 16'h0100; x_mem[10'h3FF] = 16'h0100; x_mem[10'h000] = 16'h0100; x_mem[10'h001] = 16'h0100;
    w_mem[10'h100] = 16'h0100; w_mem[10'h101] = 16'h0200; w_mem[10'h102] = 16'h0300; w_mem[10'h103] = 16'h0400;
    x_mem[10'h060] = 16'h0100; x_mem[10'h061] = 16'h0100;
    w_mem[10'h260] = 16'h0100; w_mem[10'h261] = 16'h0100;

    test_reset();
    test_basic();
    test_zero_len();
    test_saturate_hold();
    test_reset_mid_run();
    test_wrap_ignore_start();
    test_back_to_back();
`ifdef MAC_SEQ_BIAS_EN
    test_bias();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
